// File: rtl/rgb_sram_writer_pkg.sv
// Shared types and constants for the RGB SRAM writer.
// The default region base and frame dimensions live here so the display side
// and any region checks can use the same values.
package rgb_sram_writer_pkg;

  // First SRAM word of the RGB region and the default frame size
  localparam logic [17:0] DEF_BASE_ADDR  = 18'd146944;
  localparam int          DEF_IMG_WIDTH  = 320;
  localparam int          DEF_IMG_HEIGHT = 240;

  // Writer FSM states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_E = 3'd1,
    S_FETCH_O = 3'd2,
    S_WR1     = 3'd3,
    S_WR2     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Which of the three packed words of a pixel pair is being produced
  typedef enum logic [1:0] {
    WSEL_W0 = 2'd0,
    WSEL_W1 = 2'd1,
    WSEL_W2 = 2'd2
  } word_sel_t;

  // One clipped 8-bit RGB pixel
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Words written per frame: every pixel pair occupies three 16-bit words
  function automatic int num_words(input int width, input int height);
    return (3 * width * height) / 2;
  endfunction

endpackage

// File: rtl/rgb_sram_writer_if.sv
// Pixel stream handshake and SRAM write port of the RGB writer.
// master: the writer (consumes pixels, drives the SRAM write port).
// slave:  the upstream pixel source / SRAM side that observes the writes.
interface rgb_sram_writer_if;

  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;

  modport master (
    input  pixel_valid,
    input  red,
    input  green,
    input  blue,
    output pixel_ready,
    output sram_address,
    output sram_write_data,
    output sram_we_n
  );

  modport slave (
    output pixel_valid,
    output red,
    output green,
    output blue,
    input  pixel_ready,
    input  sram_address,
    input  sram_write_data,
    input  sram_we_n
  );

endinterface

// File: rtl/rgb_sram_writer_pair_packer.sv
// Combinational packer: selects one of the three 16-bit words of an
// even/odd pixel pair.  w0={R_E,G_E}, w1={B_E,R_O}, w2={G_O,B_O}.
module rgb_pair_packer
  import rgb_sram_writer_pkg::*;
(
  input  pixel_t      pix_e,
  input  pixel_t      pix_o,
  input  word_sel_t   sel,
  output logic [15:0] word
);

  // Word mux; an unused selector code yields zero rather than stale data
  always_comb begin
    word = 16'd0;
    case (sel)
      WSEL_W0: word = {pix_e.r, pix_e.g};
      WSEL_W1: word = {pix_e.b, pix_o.r};
      WSEL_W2: word = {pix_o.g, pix_o.b};
      default: word = 16'd0;
    endcase
  end

endmodule

// File: rtl/rgb_sram_writer.sv
// Final stage of the decoder datapath: takes a raster-order RGB pixel stream,
// packs each even/odd pair into three 16-bit words and writes them to
// consecutive addresses of the SRAM RGB region.  All SRAM outputs are
// registered; a write decided in one state appears on the bus one cycle later
// and lasts exactly one cycle.
module rgb_sram_writer
  import rgb_sram_writer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int          IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int          IMG_HEIGHT = DEF_IMG_HEIGHT
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  rgb_sram_writer_if.master bus
);

  localparam int          NUM_WORDS = num_words(IMG_WIDTH, IMG_HEIGHT);
  localparam int          LAST_INT  = int'(BASE_ADDR) + NUM_WORDS - 1;
  // Address of the final word of the frame (w2 of the last pair)
  localparam logic [17:0] LAST_ADDR = 18'(LAST_INT);

  // State and datapath registers
  state_t      state_r;
  logic [17:0] ptr_r;
  pixel_t      pix_e_r;
  pixel_t      pix_o_r;

  // Registered outputs
  logic        busy_r;
  logic        done_r;
  logic [17:0] addr_r;
  logic [15:0] data_r;
  logic        we_n_r;

  // Decisions made by the FSM this cycle
  state_t      state_next_s;
  logic        ready_s;
  logic        latch_e_s;
  logic        latch_o_s;
  logic        wr_en_s;
  word_sel_t   wr_sel_s;
  logic [17:0] wr_addr_s;
  logic [15:0] wr_data_s;
  logic        ptr_load_s;
  logic        ptr_adv_s;
  logic        busy_set_s;
  logic        finish_s;
  logic        last_pair_s;
  pixel_t      pix_in_s;

  assign pix_in_s = {bus.red, bus.green, bus.blue};

  // The pair being written ends the frame when its w2 lands on the last word
  assign last_pair_s = ((ptr_r + 18'd2) == LAST_ADDR);

  rgb_pair_packer u_packer (
    .pix_e (pix_e_r),
    .pix_o (pix_o_r),
    .sel   (wr_sel_s),
    .word  (wr_data_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic, handshake ready and write scheduling
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    latch_e_s    = 1'b0;
    latch_o_s    = 1'b0;
    wr_en_s      = 1'b0;
    wr_sel_s     = WSEL_W0;
    wr_addr_s    = ptr_r;
    ptr_load_s   = 1'b0;
    ptr_adv_s    = 1'b0;
    busy_set_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          ptr_load_s   = 1'b1;
          busy_set_s   = 1'b1;
          state_next_s = S_FETCH_E;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH_E: begin
        ready_s = 1'b1;
        if (bus.pixel_valid) begin
          latch_e_s    = 1'b1;
          state_next_s = S_FETCH_O;
        end else begin
          state_next_s = S_FETCH_E;
        end
      end
      S_FETCH_O: begin
        ready_s = 1'b1;
        if (bus.pixel_valid) begin
          // w0 only needs the even pixel, which is already held
          latch_o_s    = 1'b1;
          wr_en_s      = 1'b1;
          wr_sel_s     = WSEL_W0;
          wr_addr_s    = ptr_r;
          state_next_s = S_WR1;
        end else begin
          state_next_s = S_FETCH_O;
        end
      end
      S_WR1: begin
        wr_en_s      = 1'b1;
        wr_sel_s     = WSEL_W1;
        wr_addr_s    = ptr_r + 18'd1;
        state_next_s = S_WR2;
      end
      S_WR2: begin
        wr_en_s   = 1'b1;
        wr_sel_s  = WSEL_W2;
        wr_addr_s = ptr_r + 18'd2;
        if (last_pair_s) begin
          state_next_s = S_DONE;
        end else begin
          // Accepting the next even pixel here keeps one write per cycle
          ptr_adv_s = 1'b1;
          ready_s   = 1'b1;
          if (bus.pixel_valid) begin
            latch_e_s    = 1'b1;
            state_next_s = S_FETCH_O;
          end else begin
            state_next_s = S_FETCH_E;
          end
        end
      end
      S_DONE: begin
        finish_s     = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Frame pointer and pixel pair holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= 18'd0;
      pix_e_r <= '0;
      pix_o_r <= '0;
    end else begin
      if (ptr_load_s) begin
        ptr_r <= BASE_ADDR;
      end else if (ptr_adv_s) begin
        ptr_r <= ptr_r + 18'd3;
      end
      if (latch_e_s) begin
        pix_e_r <= pix_in_s;
      end
      if (latch_o_s) begin
        pix_o_r <= pix_in_s;
      end
    end
  end

  // SRAM write port: address/data hold their last value, we_n pulses low
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= 18'd0;
      data_r <= 16'd0;
      we_n_r <= 1'b1;
    end else begin
      we_n_r <= ~wr_en_s;
      if (wr_en_s) begin
        addr_r <= wr_addr_s;
        data_r <= wr_data_s;
      end
    end
  end

  // Busy spans the frame; done is a single-cycle pulse after the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (busy_set_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy                = busy_r;
  assign done                = done_r;
  assign bus.pixel_ready     = ready_s;
  assign bus.sram_address    = addr_r;
  assign bus.sram_write_data = data_r;
  assign bus.sram_we_n       = we_n_r;

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Self-checking bench for rgb_sram_writer.  Uses a small frame placed at the
// very top of SRAM so the final write lands on address 262143.  Expected SRAM
// contents come from a pixel-list model: pair k writes words at base+3k..+2.
module tb_rgb_sram_writer;
  import rgb_sram_writer_pkg::*;

  localparam logic [17:0] BASE  = 18'd262096;
  localparam int          W     = 8;
  localparam int          H     = 4;
  localparam int          NPIX  = W * H;
  localparam int          NUM   = (3 * NPIX) / 2;
  localparam int          PAIRS = NPIX / 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  rgb_sram_writer_if bus_if ();

  rgb_sram_writer #(
    .BASE_ADDR  (BASE),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed write log and done pulses
  logic [17:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  // Driver log
  int          xfer_cyc_q[$];
  int          xfer_it_q[$];
  logic        ready_q[$];
  int          start_cyc;

  // Current frame contents
  logic [7:0]  px_r[NPIX];
  logic [7:0]  px_g[NPIX];
  logic [7:0]  px_b[NPIX];

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (bus_if.sram_we_n === 1'b0) begin
      wr_addr_q.push_back(bus_if.sram_address);
      wr_data_q.push_back(bus_if.sram_write_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Expected word at a region offset, straight from the packing rule
  function automatic logic [15:0] exp_word(input int off);
    int k;
    int e;
    int o;
    k = off / 3;
    e = 2 * k;
    o = 2 * k + 1;
    case (off % 3)
      0:       return {px_r[e], px_g[e]};
      1:       return {px_b[e], px_r[o]};
      default: return {px_g[o], px_b[o]};
    endcase
  endfunction

  // Counts logged writes that disagree with the model: wrong data, outside
  // the region, duplicated, or region words never written
  function automatic int frame_errors();
    int bad;
    int off;
    bit seen[NUM];
    bad = 0;
    for (int i = 0; i < NUM; i++) seen[i] = 1'b0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      off = int'(wr_addr_q[i]) - int'(BASE);
      if (off < 0 || off >= NUM) begin
        bad++;
      end else begin
        if (seen[off]) bad++;
        seen[off] = 1'b1;
        if (wr_data_q[i] !== exp_word(off)) bad++;
      end
    end
    for (int i = 0; i < NUM; i++) if (!seen[i]) bad++;
    return bad;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'($urandom);
      px_g[i] = 8'($urandom);
      px_b[i] = 8'($urandom);
    end
  endtask

  // Starts a frame and streams the pixel list until done (or until
  // abort_writes writes have been seen, when abort_writes > 0)
  task automatic stream_frame(input int bubble_pct, input bit spam_start,
                              input int abort_writes,
                              output int xfers, output bit timed_out);
    int idx;
    int d0;
    idx = 0;
    d0  = done_cnt;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    xfer_cyc_q.delete();
    xfer_it_q.delete();
    ready_q.delete();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    timed_out = 1'b1;
    for (int it = 0; it < 4000; it++) begin
      if (done_cnt != d0) begin
        timed_out = 1'b0;
        break;
      end
      if (abort_writes > 0 && wr_addr_q.size() >= abort_writes) begin
        timed_out = 1'b0;
        break;
      end
      start = spam_start ? ($urandom_range(3) == 0) : 1'b0;
      if (idx < NPIX && $urandom_range(99) >= bubble_pct) begin
        bus_if.pixel_valid = 1'b1;
        bus_if.red   = px_r[idx];
        bus_if.green = px_g[idx];
        bus_if.blue  = px_b[idx];
      end else begin
        bus_if.pixel_valid = 1'b0;
        bus_if.red   = 8'($urandom);
        bus_if.green = 8'($urandom);
        bus_if.blue  = 8'($urandom);
      end
      ready_q.push_back(bus_if.pixel_ready);
      if (bus_if.pixel_valid && bus_if.pixel_ready) begin
        xfer_cyc_q.push_back(cyc);
        xfer_it_q.push_back(it);
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus_if.pixel_valid = 1'b0;
    xfers = idx;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    bus_if.pixel_valid = 1'b0;
    bus_if.red   = 8'd0;
    bus_if.green = 8'd0;
    bus_if.blue  = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (bus_if.sram_we_n !== 1'b1 || bus_if.sram_address !== 18'd0 ||
        bus_if.sram_write_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_sram we_n=%b addr=%0d data=%h required 1 0 0000",
               bus_if.sram_we_n, bus_if.sram_address, bus_if.sram_write_data);
    end
    checks++;
    if (bus_if.pixel_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b required 0", bus_if.pixel_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_pair();
    int  n;
    bit  to;
    int  j;
    fill_random();
    px_r[0] = 8'h11; px_g[0] = 8'h22; px_b[0] = 8'h33;
    px_r[1] = 8'h44; px_g[1] = 8'h55; px_b[1] = 8'h66;
    stream_frame(0, 1'b0, 0, n, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL first_pair_timeout done not seen within budget");
    end
    checks++;
    if (wr_addr_q.size() < 3) begin
      errors++;
      $display("FAIL first_pair_count got %0d writes required >=3", wr_addr_q.size());
    end else begin
      if (wr_addr_q[0] !== BASE || wr_data_q[0] !== 16'h1122 ||
          wr_addr_q[1] !== BASE + 18'd1 || wr_data_q[1] !== 16'h3344 ||
          wr_addr_q[2] !== BASE + 18'd2 || wr_data_q[2] !== 16'h5566) begin
        errors++;
        $display("FAIL first_pair_words got %h@%0d %h@%0d %h@%0d required 1122@%0d 3344@+1 5566@+2",
                 wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1],
                 wr_data_q[2], wr_addr_q[2], BASE);
      end
      checks++;
      if (wr_cyc_q[1] !== wr_cyc_q[0] + 1 || wr_cyc_q[2] !== wr_cyc_q[0] + 2) begin
        errors++;
        $display("FAIL first_pair_spacing cycles %0d %0d %0d required consecutive",
                 wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]);
      end
      checks++;
      if (xfer_cyc_q.size() < 2 || wr_cyc_q[0] !== xfer_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL w0_latency w0 cycle %0d required odd transfer + 1", wr_cyc_q[0]);
      end
    end
    if (xfer_it_q.size() == NPIX) begin
      j = xfer_it_q[1];
      checks++;
      if (ready_q[j + 1] !== 1'b0 || ready_q[j + 2] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_odd got %b%b required 01", ready_q[j + 1], ready_q[j + 2]);
      end
      j = xfer_it_q[NPIX - 1];
      checks++;
      if (ready_q.size() <= j + 3 || ready_q[j + 2] !== 1'b0 || ready_q[j + 3] !== 1'b0) begin
        errors++;
        $display("FAIL ready_at_end ready not low in last WR2/DONE cycles");
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL first_pair_xfers got %0d required %0d", xfer_it_q.size(), NPIX);
    end
  endtask

  task automatic test_full_frame();
    int n;
    bit to;
    int bad;
    int span;
    fill_random();
    stream_frame(0, 1'b0, 0, n, to);
    bad = frame_errors();
    checks++;
    if (to !== 1'b0 || n !== NPIX) begin
      errors++;
      $display("FAIL full_xfers timeout=%b consumed=%0d required 0 %0d", to, n, NPIX);
    end
    checks++;
    if (wr_addr_q.size() !== NUM || bad !== 0) begin
      errors++;
      $display("FAIL full_contents writes=%0d bad=%0d required %0d 0", wr_addr_q.size(), bad, NUM);
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 18'd262143 ||
        done_cyc !== wr_cyc_q[wr_cyc_q.size() - 1] + 1) begin
      errors++;
      $display("FAIL full_done_timing done=%0d last write must be 262143 one cycle earlier", done_cyc);
    end
    span = done_cyc - start_cyc;
    checks++;
    if (span < 3 * PAIRS - 3 || span > 3 * PAIRS + 3) begin
      errors++;
      $display("FAIL full_cycles got %0d required %0d +/- 3", span, 3 * PAIRS);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus_if.sram_we_n !== 1'b1) begin
      errors++;
      $display("FAIL full_idle busy=%b we_n=%b required 0 1", busy, bus_if.sram_we_n);
    end
  endtask

  task automatic test_bubbles();
    int n;
    bit to;
    int bad;
    int late;
    fill_random();
    stream_frame(30, 1'b0, 0, n, to);
    bad = frame_errors();
    checks++;
    if (to !== 1'b0 || wr_addr_q.size() !== NUM || bad !== 0) begin
      errors++;
      $display("FAIL bubble_contents timeout=%b writes=%0d bad=%0d required 0 %0d 0",
               to, wr_addr_q.size(), bad, NUM);
    end
    // Each pair's three writes follow its odd-pixel transfer exactly
    late = 0;
    if (xfer_cyc_q.size() == NPIX && wr_cyc_q.size() == NUM) begin
      for (int k = 0; k < PAIRS; k++)
        for (int w = 0; w < 3; w++)
          if (wr_cyc_q[3 * k + w] !== xfer_cyc_q[2 * k + 1] + 1 + w) late++;
    end else begin
      late = -1;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL bubble_write_timing misplaced=%0d required 0", late);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit to;
    int bad;
    fill_random();
    stream_frame(0, 1'b0, 32, n, to);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 32) begin
      errors++;
      $display("FAIL reset_no_w2 writes=%0d required 32", wr_addr_q.size());
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus_if.sram_we_n !== 1'b1 ||
        bus_if.sram_address !== 18'd0 || bus_if.sram_write_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs busy=%b done=%b we_n=%b addr=%0d data=%h required 0 0 1 0 0000",
               busy, done, bus_if.sram_we_n, bus_if.sram_address, bus_if.sram_write_data);
    end
    rst = 1'b0;
    @(negedge clk);
    fill_random();
    stream_frame(0, 1'b0, 0, n, to);
    bad = frame_errors();
    checks++;
    if (to !== 1'b0 || wr_addr_q.size() == 0 || wr_addr_q[0] !== BASE || bad !== 0) begin
      errors++;
      $display("FAIL reset_restart timeout=%b first=%0d bad=%0d required 0 %0d 0",
               to, (wr_addr_q.size() > 0) ? int'(wr_addr_q[0]) : -1, bad, BASE);
    end
  endtask

  task automatic test_start_spam_idle_valid();
    int n;
    bit to;
    int bad;
    int d0;
    int rdy_bad;
    int w0;
    w0 = wr_addr_q.size();
    rdy_bad = 0;
    bus_if.pixel_valid = 1'b1;
    bus_if.red   = 8'hDE;
    bus_if.green = 8'hAD;
    bus_if.blue  = 8'hBE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.pixel_ready !== 1'b0) rdy_bad++;
    end
    checks++;
    if (rdy_bad !== 0 || wr_addr_q.size() !== w0) begin
      errors++;
      $display("FAIL idle_valid ready_high=%0d new_writes=%0d required 0 0",
               rdy_bad, wr_addr_q.size() - w0);
    end
    d0 = done_cnt;
    fill_random();
    stream_frame(10, 1'b1, 0, n, to);
    repeat (6) @(negedge clk);
    bad = frame_errors();
    checks++;
    if (to !== 1'b0 || wr_addr_q.size() !== NUM || bad !== 0) begin
      errors++;
      $display("FAIL spam_contents timeout=%b writes=%0d bad=%0d required 0 %0d 0",
               to, wr_addr_q.size(), bad, NUM);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL spam_done_once pulses=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_golden();
    int n;
    bit to;
    int bad;
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'(i * 37 + 5);
      px_g[i] = 8'(255 - i * 11);
      px_b[i] = 8'(i) ^ 8'hA5;
    end
    stream_frame(15, 1'b0, 0, n, to);
    bad = frame_errors();
    checks++;
    if (to !== 1'b0 || wr_addr_q.size() !== NUM || bad !== 0) begin
      errors++;
      $display("FAIL golden timeout=%b writes=%0d bad=%0d required 0 %0d 0",
               to, wr_addr_q.size(), bad, NUM);
    end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_full_frame();
    test_bubbles();
    test_reset_mid_frame();
    test_start_spam_idle_valid();
    test_golden();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
